wb_trace_buffer: RTL and testbench

- Downstream consumer of the CPU core's write-back debug trace (have_inst / pc / ena / reg / value).
- Captures each retired instruction's write-back record into a first-word-fall-through FIFO.
- The FIFO is drained by a valid/ready consumer, such as a trace comparator or UART dumper, without stalling the core.
- Counts retirements and dropped records, and flags overflow.

---
 rtl/wb_trace_buffer.sv | 100 ++++++++++
 tb/tb_wb_trace_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture FIFO (FWFT, one-cycle write latency, drops when full; consumer stalls via out_ready).
// Optional WB_TRACE_ONLY_WRITES_EN: buffer only architectural register writes (ena=1, reg!=0).
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wb_have_inst,
  input  logic [31:0]   wb_pc,
  input  logic          wb_ena,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_value,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic          out_ena,
  output logic [4:0]    out_reg,
  output logic [31:0]   out_value,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  output logic [31:0]   retire_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  dst;
    logic [31:0] value;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          cap;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

`ifdef WB_TRACE_ONLY_WRITES_EN
  assign cap = wb_have_inst & wb_ena & (wb_reg != 5'd0);
`else
  assign cap = wb_have_inst;
`endif

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push      = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wptr] <= '{pc: wb_pc, ena: wb_ena, dst: wb_reg, value: wb_value};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      retire_cnt <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      if (wb_have_inst) retire_cnt <= retire_cnt + 32'd1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign head      = mem[rptr];
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_ena   = out_valid ? head.ena   : 1'b0;
  assign out_reg   = out_valid ? head.dst   : '0;
  assign out_value = out_valid ? head.value : '0;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: queue-based reference model, negedge monitor.
module tb_wb_trace_buffer;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wb_have_inst = 1'b0;
  logic [31:0]   wb_pc = '0;
  logic          wb_ena = 1'b0;
  logic [4:0]    wb_reg = '0;
  logic [31:0]   wb_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic          out_ena;
  logic [4:0]    out_reg;
  logic [31:0]   out_value;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [31:0]   retire_cnt;

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
    .wb_reg(wb_reg), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ena(out_ena), .out_reg(out_reg), .out_value(out_value),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
  } rec_t;

  rec_t exp_q[$];
  int   m_count;
  bit   m_ovf;
  int   m_drops;
  logic [31:0] m_retire;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_cap(input logic hv, input logic en, input logic [4:0] rg);
`ifdef WB_TRACE_ONLY_WRITES_EN
    return hv && en && (rg != 5'd0);
`else
    return hv;
`endif
  endfunction

  // Monitor: compares every observable output against the model each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_count != 0));
      chk("count", 64'(count), 64'(m_count));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("retire_cnt", 64'(retire_cnt), 64'(m_retire));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("head_present", 64'(0), 64'(1));
        end else begin
          chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
          chk("out_ena", 64'(out_ena), 64'(exp_q[0].ena));
          chk("out_reg", 64'(out_reg), 64'(exp_q[0].rg));
          chk("out_value", 64'(out_value), 64'(exp_q[0].val));
          if (out_ready && !clear) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data", {out_pc, out_value}, 64'(0));
        chk("idle_ctl", 64'({out_ena, out_reg}), 64'(0));
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_drops = 0;
    m_retire = '0;
  endtask

  // One clock cycle of stimulus; model state advances just after the edge.
  task automatic cycle(input logic hv, input logic [31:0] pc, input logic en,
                       input logic [4:0] rg, input logic [31:0] val,
                       input logic rdy, input logic clr);
    bit c, p;
    wb_have_inst = hv; wb_pc = pc; wb_ena = en; wb_reg = rg; wb_value = val;
    out_ready = rdy; clear = clr;
    @(negedge clk);
    c = model_cap(hv, en, rg);
    p = rdy && (m_count > 0);
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      if (hv) m_retire = m_retire + 32'd1;
      if (c && (m_count < DEPTH || p)) begin
        exp_q.push_back('{pc: pc, ena: en, rg: rg, val: val});
        m_count++;
      end else if (c) begin
        m_ovf = 1'b1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
      if (p) m_count--;
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    wb_have_inst = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flags", {overflow, drop_cnt, retire_cnt}, 64'(0));
    chk("rst_data", {out_pc, out_value}, 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    do_reset();

    // Three retirements held, then drained in order.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'(i * 4), 1'b1, 5'(i + 1), 32'(8'h11 * (i + 1)), 1'b0, 1'b0);
    chk("t1_count", 64'(count), 64'(3));
    chk("t1_pc", 64'(out_pc), 64'(0));
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t1_empty", 64'({out_valid, count}), 64'(0));

    // Overflow by two records.
    cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 5'((i % 31) + 1), 32'hA000 + 32'(i), 1'b0, 1'b0);
    chk("t2_count", 64'(count), 64'(DEPTH));
    chk("t2_ovf", 64'(overflow), 64'(1));
    chk("t2_drops", 64'(drop_cnt), 64'(2));
    chk("t2_retire", 64'(retire_cnt), 64'(DEPTH + 2));

    // Full with a simultaneous retirement and pop.
    cycle(1'b1, 32'hBEEF0000, 1'b1, 5'd7, 32'h5555AAAA, 1'b1, 1'b0);
    chk("t3_count", 64'(count), 64'(DEPTH));
    chk("t3_drops", 64'(drop_cnt), 64'(2));
    for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
    chk("t3_tail", 64'(out_pc), 64'h0BEEF0000);
    idle(1'b1);

    // Push into empty, then pointer wrap with paired push/pop.
    for (int i = 0; i < 3 * DEPTH; i++)
      cycle(1'b1, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0);
    idle(1'b1);

    // Clear with concurrent retirement while overflowed and holding 5.
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b1, $urandom, 1'b1, 5'd9, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) idle(1'b1);
    chk("t5_pre_count", 64'(count), 64'(5));
    chk("t5_pre_ovf", 64'(overflow), 64'(1));
    cycle(1'b1, 32'hC1EA0000, 1'b1, 5'd3, 32'h1, 1'b0, 1'b1);
    chk("t5_count", 64'(count), 64'(0));
    chk("t5_flags", {overflow, drop_cnt, retire_cnt}, 64'(0));

    // Filtered capture.
    cycle(1'b1, 32'h100, 1'b1, 5'd5, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, 1'b0, 5'd5, 32'h66, 1'b0, 1'b0);
    cycle(1'b1, 32'h108, 1'b1, 5'd0, 32'h77, 1'b0, 1'b0);
`ifdef WB_TRACE_ONLY_WRITES_EN
    chk("t6_count", 64'(count), 64'(1));
`else
    chk("t6_count", 64'(count), 64'(3));
`endif
    chk("t6_reg", 64'(out_reg), 64'(5));
    chk("t6_retire", 64'(retire_cnt), 64'(3));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic with occasional clear and one mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      logic rdy;
      if (n == 1500) do_reset();
      rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, rdy, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("end_empty", 64'(count), 64'(0));

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
